// File: rtl/dot_product_seq_pkg.sv
// Shared constants for the dot-product sequencer: ALU opcodes, data width, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dot_product_seq_pkg;

  localparam int DP_DATA_W = 16;
  localparam int DP_ADDR_W = 8;

  // 3-bit ALU opcodes; the 4-bit alu_control bus carries these with bit 3 tied low
  localparam logic [2:0] OP_NO_OPERATION = 3'b000;
  localparam logic [2:0] OP_MUL          = 3'b001;
  localparam logic [2:0] OP_ADD          = 3'b010;
  localparam logic [2:0] OP_SUB          = 3'b011;
  localparam logic [2:0] OP_DIV          = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_A    = 3'd1,
    ST_RD_B    = 3'd2,
    ST_LATCH_B = 3'd3,
    ST_MUL     = 3'd4,
    ST_ADD     = 3'd5,
    ST_ACC     = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

endpackage

// File: rtl/dot_product_seq_if.sv
// Bundle of the sequencer's control handshake, operand-memory and ALU signals.
// Latency: n/a (wires only).
// Backpressure: none; start is simply ignored while the sequencer is busy.
interface dot_product_seq_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] stride_b;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [3:0]        alu_control;
  logic [DATA_W-1:0] alu_out;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  // the sequencer itself
  modport master (
    input  start, base_a, base_b, stride_b, mem_rd_data, alu_out,
    output mem_addr, alu_in1, alu_in2, alu_control, busy, done, result
  );

  // requester, operand memory and ALU
  modport slave (
    output start, base_a, base_b, stride_b, mem_rd_data, alu_out,
    input  mem_addr, alu_in1, alu_in2, alu_control, busy, done, result
  );
endinterface

// File: rtl/dot_product_seq.sv
// Computes sum A[k]*B[k] over VEC_LEN pairs by time-sharing an external registered ALU.
// Latency: done pulses 6*VEC_LEN+1 cycles after start is sampled in IDLE.
// Backpressure: start is ignored unless idle; no queuing of requests.
module dot_product_seq
  import dot_product_seq_pkg::*;
#(
  parameter int VEC_LEN = 3,
  parameter int ADDR_W  = DP_ADDR_W,
  parameter int DATA_W  = DP_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  dot_product_seq_if.master bus
);

  localparam int K_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(VEC_LEN - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] a_ptr, b_ptr, stride;
  logic [DATA_W-1:0] opa, opb, acc, result_q;
  logic [DATA_W-1:0] in1_q, in2_q;
  logic [K_W-1:0]    k;

  // State register plus datapath registers that update on specific states
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_ptr    <= '0;
      b_ptr    <= '0;
      stride   <= '0;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      result_q <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      k        <= '0;
    end else begin
      state <= state_nxt;
      // ALU operands hold their last driven value outside MUL/ADD
      in1_q <= bus.alu_in1;
      in2_q <= bus.alu_in2;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_ptr  <= bus.base_a;
            b_ptr  <= bus.base_b;
            stride <= bus.stride_b;
            k      <= '0;
            acc    <= '0;
          end
        end
        ST_RD_B:    opa <= bus.mem_rd_data;
        ST_LATCH_B: opb <= bus.mem_rd_data;
        ST_ACC: begin
          // ALU is under NO_OPERATION here, so alu_out still holds the ADD result
          acc   <= bus.alu_out;
          a_ptr <= a_ptr + ADDR_W'(1);
          b_ptr <= b_ptr + stride;
          if (k == K_LAST) begin
            // result lands together with acc so it is valid while done is high
            result_q <= bus.alu_out;
          end else begin
            k <= k + K_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt       = state;
    bus.mem_addr    = '0;
    bus.alu_in1     = in1_q;
    bus.alu_in2     = in2_q;
    bus.alu_control = {1'b0, OP_NO_OPERATION};
    bus.busy        = (state != ST_IDLE);
    bus.done        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = ST_RD_A;
      end
      ST_RD_A: begin
        bus.mem_addr = a_ptr;
        state_nxt    = ST_RD_B;
      end
      ST_RD_B: begin
        bus.mem_addr = b_ptr;
        state_nxt    = ST_LATCH_B;
      end
      ST_LATCH_B: state_nxt = ST_MUL;
      ST_MUL: begin
        bus.alu_in1     = opa;
        bus.alu_in2     = opb;
        bus.alu_control = {1'b0, OP_MUL};
        state_nxt       = ST_ADD;
      end
      ST_ADD: begin
        bus.alu_in1     = bus.alu_out;
        bus.alu_in2     = acc;
        bus.alu_control = {1'b0, OP_ADD};
        state_nxt       = ST_ACC;
      end
      ST_ACC: state_nxt = (k == K_LAST) ? ST_DONE : ST_RD_A;
      ST_DONE: begin
        bus.done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_dot_product_seq.sv
// Bench for dot_product_seq: behavioural memory and ALU, reference dot product model.
// Latency: expects done 6*VL+1 cycles after start.
// Backpressure: exercises ignored and held start requests.
module tb_dot_product_seq;
  localparam int VL  = 3;
  localparam int LAT = 6 * VL + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dot_product_seq_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  dot_product_seq #(.VEC_LEN(VL), .ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // operand memory with one-cycle read latency
  logic [15:0] mem [256];
  logic [15:0] rd_q = '0;
  always @(posedge clk) rd_q <= mem[bus.mem_addr];
  assign bus.mem_rd_data = rd_q;

  // registered ALU that holds its output under NO_OPERATION
  logic [15:0] alu_q = '0;
  always @(posedge clk) begin
    case (bus.alu_control)
      4'b0001: alu_q <= 16'(bus.alu_in1 * bus.alu_in2);
      4'b0010: alu_q <= bus.alu_in1 + bus.alu_in2;
      default: alu_q <= alu_q;
    endcase
  end
  assign bus.alu_out = alu_q;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  // reference: plain modular dot product over wrapped addresses
  task automatic model(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] sb,
                       output logic [15:0] exp, output logic [7:0] ea [VL], output logic [7:0] eb [VL]);
    exp = '0;
    for (int j = 0; j < VL; j++) begin
      ea[j] = ba + 8'(j);
      eb[j] = bb + 8'(sb * j);
      exp   = 16'(exp + 16'(mem[ea[j]] * mem[eb[j]]));
    end
  endtask

  // one complete operation; poke>0 re-pulses start at that cycle
  task automatic run_op(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] sb,
                        input int poke, input string tag);
    logic [15:0] exp;
    logic [7:0]  ea [VL];
    logic [7:0]  eb [VL];
    logic [7:0]  ta [VL];
    logic [7:0]  tb [VL];
    logic [15:0] res_at_done;
    int done_cnt, done_at, busy_bad, op_bad;
    model(ba, bb, sb, exp, ea, eb);
    done_cnt = 0; done_at = -1; busy_bad = 0; op_bad = 0; res_at_done = 'x;
    bus.base_a = ba; bus.base_b = bb; bus.stride_b = sb;
    bus.start = 1'b1;
    for (int n = 1; n <= LAT + 8; n++) begin
      tick();
      bus.start = (n == poke);
      for (int j = 0; j < VL; j++) begin
        if (n == 1 + 6 * j) ta[j] = bus.mem_addr;
        if (n == 2 + 6 * j) tb[j] = bus.mem_addr;
      end
      if (bus.busy !== (n <= LAT)) busy_bad++;
      if (bus.alu_control[3] !== 1'b0 || bus.alu_control[2:0] > 3'd2) op_bad++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_at = n;
        res_at_done = bus.result;
      end
    end
    check({tag, ".done_cnt"}, done_cnt, 1);
    check({tag, ".latency"}, done_at, LAT);
    check({tag, ".result"}, res_at_done, exp);
    check({tag, ".result_held"}, bus.result, exp);
    check({tag, ".busy_window"}, busy_bad, 0);
    check({tag, ".opcodes"}, op_bad, 0);
    for (int j = 0; j < VL; j++) begin
      check($sformatf("%s.addr_a%0d", tag, j), ta[j], ea[j]);
      check($sformatf("%s.addr_b%0d", tag, j), tb[j], eb[j]);
    end
  endtask

  initial begin
    int dones [$];
    logic [15:0] dres [$];
    logic [15:0] exp;
    logic [7:0]  ea [VL];
    logic [7:0]  eb [VL];
    int bad;

    clear_mem();
    rst = 1'b1;
    bus.start = 1'b0; bus.base_a = '0; bus.base_b = '0; bus.stride_b = '0;
    tick(); tick();

    // reset state
    check("rst.busy", bus.busy, 0);
    check("rst.done", bus.done, 0);
    check("rst.result", bus.result, 0);
    check("rst.alu_control", bus.alu_control, 0);
    check("rst.mem_addr", bus.mem_addr, 0);
    check("rst.alu_in1", bus.alu_in1, 0);
    check("rst.alu_in2", bus.alu_in2, 0);
    rst = 1'b0;
    tick();

    // basic row dot product: 1*4+2*5+3*6 = 32
    mem[8'h00] = 16'd1; mem[8'h01] = 16'd2; mem[8'h02] = 16'd3;
    mem[8'h10] = 16'd4; mem[8'h11] = 16'd5; mem[8'h12] = 16'd6;
    run_op(8'h00, 8'h10, 8'd1, 0, "t1");
    check("t1.const", bus.result, 16'h0020);

    // column stride of 3
    clear_mem();
    mem[8'h00] = 16'd1; mem[8'h01] = 16'd1; mem[8'h02] = 16'd1;
    mem[8'h20] = 16'd7; mem[8'h23] = 16'd8; mem[8'h26] = 16'd9;
    run_op(8'h00, 8'h20, 8'd3, 0, "t2");
    check("t2.const", bus.result, 16'd24);

    // truncation and wrap of the accumulator
    clear_mem();
    mem[8'h00] = 16'h0100; mem[8'h01] = 16'hFFFF; mem[8'h02] = 16'h0000;
    mem[8'h10] = 16'h0100; mem[8'h11] = 16'h0001; mem[8'h12] = 16'h0005;
    run_op(8'h00, 8'h10, 8'd1, 0, "t3a");
    check("t3a.const", bus.result, 16'hFFFF);
    mem[8'h00] = 16'hFFFF; mem[8'h01] = 16'h0001; mem[8'h02] = 16'h0000;
    mem[8'h10] = 16'h0001; mem[8'h11] = 16'h0001; mem[8'h12] = 16'h0000;
    run_op(8'h00, 8'h10, 8'd1, 0, "t3b");
    check("t3b.const", bus.result, 16'h0000);

    // start re-pulsed mid-operation is ignored
    clear_mem();
    mem[8'h00] = 16'd1; mem[8'h01] = 16'd2; mem[8'h02] = 16'd3;
    mem[8'h10] = 16'd4; mem[8'h11] = 16'd5; mem[8'h12] = 16'd6;
    run_op(8'h00, 8'h10, 8'd1, 5, "t4a");

    // start held high: back-to-back operations, done every LAT+1 cycles
    model(8'h00, 8'h10, 8'd1, exp, ea, eb);
    bus.base_a = 8'h00; bus.base_b = 8'h10; bus.stride_b = 8'd1;
    bus.start = 1'b1;
    for (int n = 1; n <= 3 * (LAT + 1) + 6; n++) begin
      tick();
      if (n == 3 * (LAT + 1) - 1) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        dones.push_back(n);
        dres.push_back(bus.result);
      end
    end
    check("t4b.done_cnt", dones.size(), 3);
    bad = 0;
    for (int i = 0; i < dones.size(); i++) begin
      if (dones[i] != (i + 1) * (LAT + 1) - 1) bad++;
      if (dres[i] !== exp) bad++;
    end
    check("t4b.spacing_and_results", bad, 0);
    check("t4b.idle_after", bus.busy, 0);

    // synchronous reset mid-operation
    bus.start = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      bus.start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5.busy", bus.busy, 0);
    check("t5.done", bus.done, 0);
    check("t5.result", bus.result, 0);
    check("t5.alu_control", bus.alu_control, 0);
    bad = 0;
    for (int n = 0; n < LAT + 4; n++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("t5.quiet_after_abort", bad, 0);
    run_op(8'h00, 8'h10, 8'd1, 0, "t5r");
    check("t5r.const", bus.result, 16'h0020);

    // address wrap at the top of memory
    clear_mem();
    mem[8'hFE] = 16'd3; mem[8'hFF] = 16'd5; mem[8'h00] = 16'd7;
    mem[8'h01] = 16'd11;
    run_op(8'hFE, 8'hFF, 8'd1, 0, "t6");

    // randomized operations
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      run_op(8'($urandom), 8'($urandom), 8'($urandom_range(0, 255)), 0,
             $sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dot_product_seq.md
Name: dot_product_seq

Overview:
Sequencer that computes one 16-bit dot product, sum over k of A[k]*B[k], by time-sharing the matrix-multiplier ALU. It fetches operands from a synchronous-read operand memory and issues MUL then ADD opcodes to the ALU for each element pair. It accumulates the result and reports completion with a start/busy/done handshake. The top level uses it once per output matrix element.

Parameters:
VEC_LEN, 3, number of element pairs per dot product (>=1)
ADDR_W, 8, operand memory address width
DATA_W, 16, operand/ALU data width (must match ALU)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request new dot product; sampled only in IDLE
base_a  in  ADDR_W  address of A[0], latched on accepted start
base_b  in  ADDR_W  address of B[0], latched on accepted start
stride_b  in  ADDR_W  B address increment per element (1 = row, matrix width = column); A stride fixed at 1
mem_addr  out  ADDR_W  operand memory read address
mem_rd_data  in  DATA_W  read data, valid the cycle after mem_addr presented
alu_in1  out  DATA_W  ALU operand 1
alu_in2  out  DATA_W  ALU operand 2
alu_control  out  4  ALU opcode; bit 3 always 0
alu_out  in  DATA_W  registered ALU result
busy  out  1  high from cycle after accepted start through DONE
done  out  1  one-cycle pulse, result valid
result  out  DATA_W  final sum, held until next accepted start or reset

Behaviour:
- Opcodes driven: NO_OPERATION=000, MUL=001, ADD=010. SUB and DIV are never issued.
- alu_control is NO_OPERATION in every state except MUL and ADD.
- The ALU holds its output under NO_OPERATION. The controller relies on this in ACC.
- FSM states: IDLE, RD_A, RD_B, LATCH_B, MUL, ADD, ACC, DONE.
- IDLE:
  - busy=0, mem_addr=0.
  - On start=1: latch a_ptr=base_a, b_ptr=base_b, stride; clear k and acc; go to RD_A.
- RD_A: mem_addr=a_ptr; go to RD_B.
- RD_B: mem_addr=b_ptr; opa<=mem_rd_data; go to LATCH_B.
- LATCH_B: opb<=mem_rd_data; go to MUL.
- MUL: alu_in1=opa, alu_in2=opb, alu_control=MUL. alu_out holds the truncated product in the next cycle. Go to ADD.
- ADD: alu_in1=alu_out, alu_in2=acc, alu_control=ADD. Go to ACC.
- ACC:
  - acc<=alu_out, a_ptr<=a_ptr+1, b_ptr<=b_ptr+stride.
  - If k==VEC_LEN-1, go to DONE; else k<=k+1 and go to RD_A.
- DONE: result<=acc (registered, visible next cycle... see note), done=1; go to IDLE.
  - Note: result is assigned at the ACC->DONE edge together with acc, so result is already valid while done=1.
- In states other than MUL/ADD, alu_in1/alu_in2 hold their last values; they are don't-care to the ALU.
- Latency: done is high exactly 6*VEC_LEN+1 cycles after the cycle in which start is sampled high. VEC_LEN=3 gives 19.
- Arithmetic: all modulo 2^DATA_W. Product truncation comes from the ALU; no overflow flag.
- Address arithmetic wraps modulo 2^ADDR_W.
- Start while busy or in DONE: ignored, no queuing. Start held high re-triggers on the first IDLE cycle after DONE.
- Reset values: state=IDLE, busy=0, done=0, result=0, alu_control=0000, mem_addr=0, acc=0, k=0, alu_in1=alu_in2=0.
- Reset mid-operation aborts immediately; the partial sum is discarded and the ALU output is left stale. Correctness never depends on the ALU output before the first MUL of an operation.

Decomposition:
- Shared package holds the ALU opcode constants (NO_OPERATION, MUL, ADD, SUB, DIV, 3-bit), DATA_W, and the FSM state encoding.
- Single flat module, no sub-module. The ALU and operand memory are instantiated beside it at the top level.

Test Plan:
1. mem[0..2]=1,2,3; mem[0x10..0x12]=4,5,6; base_a=0, base_b=0x10, stride_b=1, start pulse -> result=32 (0x0020), done 19 cycles after start, busy high for cycles 1-19.
2. A=1,1,1 at 0x00; B at 0x20, 0x23, 0x26 = 7,8,9, stride_b=3 -> result=24, mem_addr trace 00,20,01,23,02,26.
3. A=0x0100,0xFFFF,0; B=0x0100,1,5 -> 0x10000 truncates to 0, then 0xFFFF, then +0 -> result=0xFFFF. Then A=0xFFFF,1,0; B=1,1,0 -> result=0x0000.
4. Start pulsed again at cycle 5 of an operation -> ignored, single done. Start held high continuously -> back-to-back operations, done pulses 20 cycles apart.
5. rst asserted at cycle 8 of an operation -> next cycle busy=0, done=0, result=0, alu_control=0000. A fresh start then yields the correct result from test 1.
6. base_a=0xFE, base_b=0xFF, stride_b=1 -> addresses wrap: A reads FE, FF, 00; B reads FF, 00, 01.
